// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and width helpers for the set-associative cache.
//               Holds the controller state enum, the index/tag/age width
//               derivations and the per-line status record.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  // Index bits needed to select one of SETS sets.
  function automatic int index_w(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  // Tag is whatever address bits remain above the index.
  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - index_w(sets);
  endfunction

  // Age / way-index width; a direct-mapped build still carries one bit so
  // that no vector collapses to zero width.
  function automatic int age_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Line status record. Tag and data widths depend on the instance
  // parameters, so those fields live in parallel per-instance arrays that are
  // indexed the same way as this record.
  typedef struct packed {
    logic valid;
    logic dirty;
  } line_flags_t;

endpackage
`default_nettype wire

// File: rtl/cache_lru.sv
`default_nettype none
// ============================================================================
// Module      : cache_lru
// Description : Combinational LRU age update for one set. The touched way
//               becomes age 0 and every way younger than its old age ages by
//               one, so the ages stay a permutation of 0..WAYS-1.
// Revision    : 1.0 - initial release
// Ports       : ages_in   - packed current ages, way i at [i*AGE_W +: AGE_W]
//               touch_way - way being hit or installed
//               ages_out  - packed next ages
// ============================================================================
module cache_lru #(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1
) (
  input  logic [WAYS*AGE_W-1:0] ages_in,
  input  logic [AGE_W-1:0]      touch_way,
  output logic [WAYS*AGE_W-1:0] ages_out
);

  logic [AGE_W-1:0] w_old_age;

  always_comb begin
    w_old_age = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_W'(i) == touch_way) w_old_age = ages_in[i*AGE_W +: AGE_W];
    end

    ages_out = ages_in;
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_W'(i) == touch_way) begin
        ages_out[i*AGE_W +: AGE_W] = '0;
      end else if (ages_in[i*AGE_W +: AGE_W] < w_old_age) begin
        ages_out[i*AGE_W +: AGE_W] = ages_in[i*AGE_W +: AGE_W] + AGE_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/assoc_cache.sv
`default_nettype none
// ============================================================================
// Module      : assoc_cache
// Description : N-way set-associative, write-back, write-allocate cache
//               controller with LRU replacement and hit/miss counters.
// Revision    : 1.0 - initial release
// Ports       : CLOCK_50, reset (async, active high)
//               cpu_req/cpu_we/cpu_addr/cpu_wdata  - CPU request (IDLE only)
//               cpu_rdata/cpu_ready                - one-cycle completion
//               busy, hit, hit_count, miss_count   - status / statistics
//               mem_req/mem_we/mem_addr/mem_wdata  - backing RAM request
//               mem_rdata/mem_ack                  - backing RAM response
// ============================================================================
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int SETS   = 4,
  parameter int WAYS   = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              busy,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        hit_count,
  output logic [7:0]        miss_count
);

  localparam int INDEX_W = index_w(SETS);
  localparam int TAG_W   = tag_w(ADDR_W, SETS);
  localparam int AGE_W   = age_w(WAYS);
  localparam int AGES_W  = WAYS * AGE_W;

  state_t r_state, w_next;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [AGE_W-1:0]  r_way;        // way being served: hit way or victim
  logic              r_lookup_hit;
  logic              r_hit;
  logic [7:0]        r_hit_cnt;
  logic [7:0]        r_miss_cnt;

  line_flags_t       r_flags [SETS][WAYS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [DATA_W-1:0] r_data  [SETS][WAYS];
  logic [AGES_W-1:0] r_age   [SETS];

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic [AGE_W-1:0]   w_hit_way;
  logic               w_inv_found;
  logic [AGE_W-1:0]   w_inv_way;
  logic [AGE_W-1:0]   w_lru_way;
  logic [AGE_W-1:0]   w_victim;
  logic               w_vic_dirty;
  logic [TAG_W-1:0]   w_sel_tag;
  logic [DATA_W-1:0]  w_sel_data;
  logic [AGE_W-1:0]   w_touch_way;
  logic [AGES_W-1:0]  w_age_next;

  assign w_idx = r_addr[INDEX_W-1:0];
  assign w_tag = r_addr[ADDR_W-1:INDEX_W];

  // Tag compare, victim choice and selection of the line at r_way.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    w_sel_tag   = '0;
    w_sel_data  = '0;
    w_vic_dirty = 1'b0;
    // Descending scan so the lowest-index invalid way wins.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!r_flags[w_idx][i].valid) begin
        w_inv_found = 1'b1;
        w_inv_way   = AGE_W'(i);
      end
      if (r_flags[w_idx][i].valid && (r_tag[w_idx][i] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(i);
      end
      if (r_age[w_idx][i*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) w_lru_way = AGE_W'(i);
      if (AGE_W'(i) == r_way) begin
        w_sel_tag  = r_tag[w_idx][i];
        w_sel_data = r_data[w_idx][i];
      end
    end
    w_victim = w_inv_found ? w_inv_way : w_lru_way;
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_W'(i) == w_victim) w_vic_dirty = r_flags[w_idx][i].valid && r_flags[w_idx][i].dirty;
    end
  end

  assign w_touch_way = (r_state == LOOKUP) ? w_hit_way : r_way;

  cache_lru #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .ages_in   (r_age[w_idx]),
    .touch_way (w_touch_way),
    .ages_out  (w_age_next)
  );

  // State register. Async reset drops mem_req immediately since the memory
  // outputs below are decoded from state alone.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (cpu_req) w_next = LOOKUP;
      end
      LOOKUP: begin
        if (w_hit)            w_next = RESPOND;
        else if (w_vic_dirty) w_next = WRITEBACK;
        else                  w_next = FILL;
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {w_sel_tag, w_idx};
        mem_wdata = w_sel_data;
        if (mem_ack) w_next = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = r_addr;
        if (mem_ack) w_next = RESPOND;
      end
      RESPOND: begin
        cpu_ready = 1'b1;
        cpu_rdata = w_sel_data;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request latch, line storage, LRU ages and statistics.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_way        <= '0;
      r_lookup_hit <= 1'b0;
      r_hit        <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_flags[s][w]                <= '0;
          r_tag[s][w]                  <= '0;
          r_data[s][w]                 <= '0;
          r_age[s][w*AGE_W +: AGE_W]   <= AGE_W'(w);
        end
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
          end
        end
        LOOKUP: begin
          r_lookup_hit <= w_hit;
          if (w_hit) begin
            r_way        <= w_hit_way;
            r_age[w_idx] <= w_age_next;
            if (r_we) begin
              for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == w_hit_way) begin
                  r_data[w_idx][w]        <= r_wdata;
                  r_flags[w_idx][w].dirty <= 1'b1;
                end
              end
            end
          end else begin
            r_way <= w_victim;
          end
        end
        FILL: begin
          // Install only on ack; a reset before then leaves the line invalid.
          if (mem_ack) begin
            r_age[w_idx] <= w_age_next;
            for (int w = 0; w < WAYS; w++) begin
              if (AGE_W'(w) == r_way) begin
                r_flags[w_idx][w].valid <= 1'b1;
                r_flags[w_idx][w].dirty <= r_we;
                r_tag[w_idx][w]         <= w_tag;
                r_data[w_idx][w]        <= r_we ? r_wdata : mem_rdata;
              end
            end
          end
        end
        RESPOND: begin
          r_hit <= r_lookup_hit;
          if (r_lookup_hit) r_hit_cnt  <= r_hit_cnt + 8'd1;
          else              r_miss_cnt <= r_miss_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign hit        = r_hit;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_assoc_cache
// Description : Self-checking bench for assoc_cache. Directed vector table,
//               hand-written reset-abort and counter-wrap sequences, random
//               accesses against an LRU-queue reference model, and a
//               direct-mapped (WAYS=1) instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_assoc_cache;

  localparam int WAYS1 = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  // 2-way instance
  logic       cpu_req, cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       cpu_ready, busy, hit;
  logic       mem_req, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ack   = 1'b0;
  logic [7:0] hit_count, miss_count;
  // direct-mapped instance
  logic       cpu_req2, cpu_we2;
  logic [4:0] cpu_addr2;
  logic [7:0] cpu_wdata2, cpu_rdata2;
  logic       cpu_ready2, busy2, hit2;
  logic       mem_req2, mem_we2;
  logic [4:0] mem_addr2;
  logic [7:0] mem_wdata2;
  logic [7:0] mem_rdata2 = 8'h00;
  logic       mem_ack2   = 1'b0;
  logic [7:0] hit_count2, miss_count2;
  int         fills2 = 0;

  int total = 0;
  int bad   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  assoc_cache #(.ADDR_W(5), .DATA_W(8), .SETS(4), .WAYS(WAYS1)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .busy(busy), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  assoc_cache #(.ADDR_W(5), .DATA_W(8), .SETS(4), .WAYS(1)) dut_dm (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .cpu_req(cpu_req2), .cpu_we(cpu_we2), .cpu_addr(cpu_addr2), .cpu_wdata(cpu_wdata2),
    .cpu_rdata(cpu_rdata2), .cpu_ready(cpu_ready2), .busy(busy2), .hit(hit2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .mem_ack(mem_ack2),
    .hit_count(hit_count2), .miss_count(miss_count2)
  );

  // ---------------- backing memory + responder for the 2-way instance -----
  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } tx_t;

  logic [7:0] bmem [32];
  tx_t        txq [$];
  bit         resp_en = 1'b1;
  int         dly = 2;

  always @(negedge CLOCK_50) begin
    tx_t t;
    if (reset || !resp_en) begin
      mem_ack = 1'b0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (dly == 0) begin
        t.we = mem_we; t.addr = mem_addr; t.wdata = mem_wdata;
        txq.push_back(t);
        if (mem_we) bmem[mem_addr] = mem_wdata;
        else        mem_rdata = bmem[mem_addr];
        mem_ack = 1'b1;
        dly = $urandom_range(0, 3);
      end else begin
        dly--;
      end
    end
  end

  // Direct-mapped instance: immediate ack, data = address + 1.
  always @(negedge CLOCK_50) begin
    if (reset || mem_ack2) begin
      mem_ack2 = 1'b0;
    end else if (mem_req2) begin
      mem_rdata2 = {3'b000, mem_addr2} + 8'd1;
      mem_ack2   = 1'b1;
      fills2++;
    end
  end

  // ---------------- reference model: per-set MRU-first queues -------------
  typedef struct {
    int         tag;
    logic [7:0] data;
    bit         dirty;
  } mline_t;

  mline_t     mset [4][$];
  logic [7:0] mmem [32];
  logic [7:0] m_hits = 8'd0;
  logic [7:0] m_miss = 8'd0;

  task automatic model_reset();
    for (int s = 0; s < 4; s++) mset[s].delete();
    m_hits = 8'd0;
    m_miss = 8'd0;
  endtask

  task automatic model_access(input bit we, input int a, input logic [7:0] wd,
                              output bit h, output logic [7:0] rd, output bit wb,
                              output logic [4:0] wba, output logic [7:0] wbd);
    int s, t, pos;
    mline_t e, v;
    s = a % 4; t = a / 4; pos = -1;
    wb = 1'b0; wba = 5'd0; wbd = 8'd0;
    for (int i = 0; i < mset[s].size(); i++) if (mset[s][i].tag == t) pos = i;
    if (pos >= 0) begin
      h = 1'b1;
      e = mset[s][pos];
      mset[s].delete(pos);
      m_hits++;
    end else begin
      h = 1'b0;
      m_miss++;
      if (mset[s].size() == WAYS1) begin
        v = mset[s].pop_back();
        if (v.dirty) begin
          wb  = 1'b1;
          wba = 5'(v.tag * 4 + s);
          wbd = v.data;
          mmem[wba] = v.data;
        end
      end
      e.tag = t; e.data = mmem[a]; e.dirty = 1'b0;
    end
    if (we) begin e.data = wd; e.dirty = 1'b1; end
    mset[s].push_front(e);
    rd = e.data;
  endtask

  // ---------------- checking helpers --------------------------------------
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic do_access(input bit we, input logic [4:0] a, input logic [7:0] wd,
                           input bit eh, input logic [7:0] erd, input bit ewb,
                           input logic [4:0] ewba, input logic [7:0] ewbd);
    int lat;
    int nexp;
    @(negedge CLOCK_50);
    txq.delete();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(posedge CLOCK_50); #1;
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
    lat = 1;
    while (!cpu_ready && lat < 100) begin
      @(posedge CLOCK_50); #1;
      lat++;
    end
    if (!cpu_ready) begin
      chk("ready_timeout", 32'(cpu_ready), 32'd1);
      return;
    end
    chk("rdata", 32'(cpu_rdata), 32'(erd));
    if (eh) chk("hit_latency", 32'(lat), 32'd2);
    @(posedge CLOCK_50); #1;
    chk("hit_flag", 32'(hit), 32'(eh));
    chk("busy_idle", 32'(busy), 32'd0);
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("miss_count", 32'(miss_count), 32'(m_miss));
    nexp = eh ? 0 : (ewb ? 2 : 1);
    chk("mem_txn_count", 32'(txq.size()), 32'(nexp));
    if (!eh && txq.size() == nexp) begin
      if (ewb) begin
        chk("wb_we", 32'(txq[0].we), 32'd1);
        chk("wb_addr", 32'(txq[0].addr), 32'(ewba));
        chk("wb_data", 32'(txq[0].wdata), 32'(ewbd));
      end
      chk("fill_we", 32'(txq[nexp-1].we), 32'd0);
      chk("fill_addr", 32'(txq[nexp-1].addr), 32'(a));
    end
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wd;
    logic       eh;
    logic [7:0] erd;
    logic       ewb;
    logic [4:0] ewba;
    logic [7:0] ewbd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    bit         h, wb;
    logic [7:0] rd, wbd;
    logic [4:0] wba;
    int         n;

    // Memory image: a*7+0x50, with address 5 holding 0x3C.
    for (int a = 0; a < 32; a++) begin
      bmem[a] = 8'(a * 7 + 8'h50);
      mmem[a] = 8'(a * 7 + 8'h50);
    end
    bmem[5] = 8'h3C;
    mmem[5] = 8'h3C;

    tbl[0] = '{1'b0, 5'd5, 8'h00, 1'b0, 8'h3C, 1'b0, 5'd0, 8'h00}; // cold miss
    tbl[1] = '{1'b0, 5'd5, 8'h00, 1'b1, 8'h3C, 1'b0, 5'd0, 8'h00}; // hit
    tbl[2] = '{1'b1, 5'd1, 8'hAA, 1'b0, 8'hAA, 1'b0, 5'd0, 8'h00}; // write miss, set 1
    tbl[3] = '{1'b0, 5'd5, 8'h00, 1'b1, 8'h3C, 1'b0, 5'd0, 8'h00}; // 5 becomes MRU
    tbl[4] = '{1'b0, 5'd9, 8'h00, 1'b0, 8'h8F, 1'b1, 5'd1, 8'hAA}; // evict dirty 1
    tbl[5] = '{1'b1, 5'd2, 8'h11, 1'b0, 8'h11, 1'b0, 5'd0, 8'h00}; // write-allocate
    tbl[6] = '{1'b0, 5'd2, 8'h00, 1'b1, 8'h11, 1'b0, 5'd0, 8'h00};
    tbl[7] = '{1'b0, 5'd1, 8'h00, 1'b0, 8'hAA, 1'b0, 5'd0, 8'h00}; // written-back value
    tbl[8] = '{1'b0, 5'd9, 8'h00, 1'b1, 8'h8F, 1'b0, 5'd0, 8'h00};
    tbl[9] = '{1'b0, 5'd5, 8'h00, 1'b0, 8'h3C, 1'b0, 5'd0, 8'h00}; // evict clean 1

    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 8'd0;
    cpu_req2 = 1'b0; cpu_we2 = 1'b0; cpu_addr2 = 5'd0; cpu_wdata2 = 8'd0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Reset state
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      model_access(tbl[i].we, int'(tbl[i].addr), tbl[i].wd, h, rd, wb, wba, wbd);
      do_access(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].eh, tbl[i].erd,
                tbl[i].ewb, tbl[i].ewba, tbl[i].ewbd);
    end

    // Reset while waiting in FILL: mem_req drops at once, line not installed.
    resp_en = 1'b0;
    @(negedge CLOCK_50);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd20;
    @(posedge CLOCK_50); #1;
    cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    chk("abort_fill_req", 32'(mem_req), 32'd1);
    chk("abort_fill_we", 32'(mem_we), 32'd0);
    chk("abort_fill_addr", 32'(mem_addr), 32'd20);
    @(posedge CLOCK_50); #4;
    reset = 1'b1;
    #1;
    chk("abort_req_drop", 32'(mem_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hit_count", 32'(hit_count), 32'd0);
    chk("abort_miss_count", 32'(miss_count), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    resp_en = 1'b1;
    dly = 0;
    model_reset();
    model_access(1'b0, 20, 8'h00, h, rd, wb, wba, wbd);
    chk("abort_model_miss", 32'(h), 32'd0);
    do_access(1'b0, 5'd20, 8'h00, h, rd, wb, wba, wbd);

    // Counter wrap: 256 hits on the now-resident line.
    for (int i = 0; i < 255; i++) begin
      model_access(1'b0, 20, 8'h00, h, rd, wb, wba, wbd);
      do_access(1'b0, 5'd20, 8'h00, h, rd, wb, wba, wbd);
    end
    chk("hit_count_255", 32'(hit_count), 32'd255);
    model_access(1'b0, 20, 8'h00, h, rd, wb, wba, wbd);
    do_access(1'b0, 5'd20, 8'h00, h, rd, wb, wba, wbd);
    chk("hit_count_wrap", 32'(hit_count), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      bit         rwe;
      logic [4:0] ra;
      logic [7:0] rwd;
      rwe = 1'($urandom_range(0, 1));
      ra  = 5'($urandom_range(0, 31));
      rwd = 8'($urandom);
      model_access(rwe, int'(ra), rwd, h, rd, wb, wba, wbd);
      do_access(rwe, ra, rwd, h, rd, wb, wba, wbd);
    end

    // Direct-mapped build: 0 and 4 share set 0, so alternating always misses.
    for (int i = 0; i < 6; i++) begin
      logic [4:0] a2;
      a2 = (i % 2 == 1) ? 5'd4 : 5'd0;
      @(negedge CLOCK_50);
      cpu_req2 = 1'b1; cpu_we2 = 1'b0; cpu_addr2 = a2;
      @(posedge CLOCK_50); #1;
      cpu_req2 = 1'b0;
      n = 0;
      while (!cpu_ready2 && n < 50) begin
        @(posedge CLOCK_50); #1;
        n++;
      end
      chk("dm_ready", 32'(cpu_ready2), 32'd1);
      chk("dm_rdata", 32'(cpu_rdata2), 32'(a2) + 32'd1);
      @(posedge CLOCK_50); #1;
      chk("dm_hit", 32'(hit2), 32'd0);
    end
    chk("dm_miss_count", 32'(miss_count2), 32'd6);
    chk("dm_hit_count", 32'(hit_count2), 32'd0);
    chk("dm_fills", 32'(fills2), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
